data_mem_ctrl: RTL and testbench

- Byte-addressed, little-endian data memory for the pipeline's MEM stage.
- Handles RV32 load/store sizes, driven by funct3, with sign or zero extension and byte-lane write enables.
- Uses a valid/ready request and response handshake with a programmable number of wait states. The LSU can therefore be tested against slow-memory timing before a cache or bus exists.
- Flags out-of-range, illegal-size and (optionally) misaligned accesses.

---
 rtl/data_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian RV32 data memory with a valid/ready handshake and wait states.
// Optional build macro DMEM_MISALIGN_TRAP_EN faults misaligned H/W accesses instead of aligning them.
module data_mem_ctrl #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_size;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              is_h, is_w, oor, bad_size, misalign, err, commit;
  logic [3:0]        be;
  logic [31:0]       wword, rword, load_val;
  logic [15:0]       rshift;

  // With zero wait states the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_wdata = wdata_q;
    end
    idx      = acc_addr[IDX_W+1:2];
    is_h     = (acc_size[1:0] == 2'b01);
    is_w     = (acc_size[1:0] == 2'b10);
    oor      = ((acc_addr >> (IDX_W + 2)) != '0);
    bad_size = (acc_size == 3'b011) || (acc_size[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (is_h && acc_addr[0]) || (is_w && (acc_addr[1:0] != 2'b00));
    lane     = acc_addr[1:0];
`else
    misalign = 1'b0;
    lane     = is_w ? 2'b00 : (is_h ? {acc_addr[1], 1'b0} : acc_addr[1:0]);
`endif
    err = oor || bad_size || misalign;
    case (acc_size[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        wword = {2{acc_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = acc_wdata;
      end
    endcase
    rword  = mem_q[idx];
    rshift = 16'(rword >> {lane, 3'b000});
    case (acc_size)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'b0, rshift[7:0]};
      3'b101:  load_val = {16'b0, rshift[15:0]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rdata_d = (err || acc_we) ? 32'd0 : load_val;
      err_d   = err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized bench for data_mem_ctrl against a byte-array reference model.
// Instance 0 runs with WAIT_STATES=0, instance 1 with WAIT_STATES=3.
module tb_data_mem_ctrl;
  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [7:0]  mb [2][NBYTES];
  int          checks;
  int          failures;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: access width in bytes, fault rules, then byte-by-byte little-endian copy.
  task automatic modelAccess(input int d, input logic we, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n;
    int a;
    logic [31:0] val;
    n     = (size[1:0] == 2'b00) ? 1 : ((size[1:0] == 2'b01) ? 2 : 4);
    err   = (addr > 32'(NBYTES - 1)) || (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
    a     = int'(addr % NBYTES);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) err = 1'b1;
`else
    a = a - (a % n);
`endif
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[d][a + i] = wdata[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val = val | (32'(mb[d][a + i]) << (8 * i));
        if (!size[2] && n < 4 && val[8*n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
        rdata = val;
      end
    end
  endtask

  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          ws;
    ws = (d == 0) ? 0 : 3;
    @(negedge clk);
    lat = 0;
    while (!req_ready[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("req_ready_idle", {31'b0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_size[d]  = size;
    req_wdata[d] = wdata;
    modelAccess(d, we, addr, size, wdata, exp_rdata, exp_err);
    @(negedge clk);
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom;
    req_size[d]  = 3'($urandom_range(0, 7));
    req_wdata[d] = $urandom;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      checkOutput("req_ready_busy", {31'b0, req_ready[d]}, 32'd0);
      req_valid[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    req_valid[d] = 1'b0;
    checkOutput("rsp_latency", 32'(lat), 32'(ws + 1));
    checkOutput("req_ready_resp", {31'b0, req_ready[d]}, 32'd0);
    checkOutput("rsp_rdata", rsp_rdata[d], exp_rdata);
    checkOutput("rsp_err", {31'b0, rsp_err[d]}, {31'b0, exp_err});
    @(negedge clk);
    checkOutput("rsp_valid_pulse", {31'b0, rsp_valid[d]}, 32'd0);
    checkOutput("req_ready_after", {31'b0, req_ready[d]}, 32'd1);
  endtask

  task automatic checkReset(input int d);
    checkOutput("rst_req_ready", {31'b0, req_ready[d]}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err[d]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  legal [5];
    logic [31:0] addr;
    logic [2:0]  size;
    int          d;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_size[k]  = '0;
      req_wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    checkReset(0);
    checkReset(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++) applyStimulus(k, 1'b1, 32'(w * 4), 3'b010, $urandom);

    applyStimulus(0, 1'b1, 32'h8, 3'b010, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'h8, 3'b010, 32'h0);
    applyStimulus(0, 1'b1, 32'h9, 3'b000, 32'h80);
    applyStimulus(0, 1'b0, 32'h9, 3'b000, 32'h0);
    applyStimulus(0, 1'b0, 32'h9, 3'b100, 32'h0);
    applyStimulus(0, 1'b0, 32'h8, 3'b010, 32'h0);
    applyStimulus(1, 1'b1, 32'hE, 3'b001, 32'h8001);
    applyStimulus(1, 1'b0, 32'hE, 3'b001, 32'h0);
    applyStimulus(1, 1'b0, 32'hE, 3'b101, 32'h0);
    applyStimulus(0, 1'b0, 32'h100, 3'b010, 32'h0);
    applyStimulus(0, 1'b1, 32'h0, 3'b011, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b0, 32'h0, 3'b010, 32'h0);
    applyStimulus(0, 1'b0, 32'h6, 3'b010, 32'h0);
    applyStimulus(1, 1'b0, 32'h7, 3'b001, 32'h0);

    // A store aborted by reset while waiting must leave memory untouched.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h4;
    req_size[1]  = 3'b010;
    req_wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    checkReset(1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", {31'b0, rsp_valid[1]}, 32'd0);
    end
    applyStimulus(1, 1'b0, 32'h4, 3'b010, 32'h0);

    for (int t = 0; t < 600; t++) begin
      d    = t % 2;
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      applyStimulus(d, 1'($urandom_range(0, 1)), addr, size, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
